multicycle_ctrl: RTL and testbench

//  Multicycle control FSM that sequences the shared DataPath (PC, IR, regfile, ALU, unified memory).

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/ctrl_out_decode.sv | 82 ++++++++
 rtl/multicycle_ctrl.sv | 93 +++++++++
 tb/tb_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// datapath mux codes and the packed control word handed to the datapath.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore output decode: registered state (plus mem_ready for the memory
// steps) to the full datapath control word.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t st,
  input  logic   rdy,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (st)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        // IR and PC+4 only commit in the cycle the fetch actually lands
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM4;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = rdy;
      end
      S_R_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCS_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl.halted = 1'b1;  // HALT and unused codes
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: state register and opcode-driven sequencing;
// the control word itself comes from ctrl_out_decode.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int STW         = 4,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic [STW-1:0] state,
  output logic           instr_done,
  output logic           halted
);

  state_t st_q, st_d;
  ctrl_t  ctrl;
  logic   rdy;

  assign rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) st_q <= S_FETCH;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_FETCH:  if (rdy) st_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) st_d = S_MEM_ADDR;
        else if (opcode == OPW'(OP_R))    st_d = S_R_EX;
        else if (opcode == OPW'(OP_BEQ))  st_d = S_BRANCH;
        else if (opcode == OPW'(OP_J))    st_d = S_JUMP;
        else if (opcode == OPW'(OP_ADDI)) st_d = S_ADDI_EX;
        else                              st_d = S_HALT;
      end
      // IR is stable here, so the lw/sw split can be taken late
      S_MEM_ADDR: begin
        if (opcode == OPW'(OP_LW))      st_d = S_MEM_RD;
        else if (opcode == OPW'(OP_SW)) st_d = S_MEM_WR;
        else                            st_d = S_HALT;
      end
      S_MEM_RD:  if (rdy) st_d = S_MEM_WB;
      S_MEM_WR:  if (rdy) st_d = S_FETCH;
      S_R_EX:    st_d = S_R_WB;
      S_ADDI_EX: st_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: st_d = S_FETCH;
      default:   st_d = S_HALT;
    endcase
  end

  ctrl_out_decode u_dec (
    .st   (st_q),
    .rdy  (rdy),
    .ctrl (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign halted        = ctrl.halted;
  assign state         = STW'(st_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: instruction-level step lists built
// from the opcode step tables, checked cycle by cycle against a control table.
module tb_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, halted;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_chk = 0;
  int n_err = 0;

  multicycle_ctrl #(.OPW(6), .STW(4), .MEM_WAIT_EN(1)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done), .halted(halted)
  );

  always #5 clock = ~clock;

  wire [19:0] dut_w = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, instr_done, halted};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Control table: state number and memory handshake -> expected word
  function automatic logic [19:0] exp_w(input int s, input bit r);
    logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0;
    logic rw = 0, sa = 0, dn = 0, hl = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    case (s)
      0:  begin mr = 1; sb = 2'd1; irw = r; pw = r; end
      1:  sb = 2'd3;
      2:  begin sa = 1; sb = 2'd2; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; iod = 1; dn = r; end
      6:  begin sa = 1; ao = 2'd2; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin sa = 1; ao = 2'd1; pwc = 1; ps = 2'd1; dn = 1; end
      9:  begin pw = 1; ps = 2'd2; dn = 1; end
      10: begin sa = 1; sb = 2'd2; end
      11: begin rw = 1; dn = 1; end
      default: hl = 1;
    endcase
    return {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, dn, hl};
  endfunction

  typedef struct { int s; bit r; } step_t;

  // Runs one instruction from FETCH. Entered and left at posedge+1.
  // wf/wm: stall cycles in FETCH and in the data-memory step.
  // abort_at >= 0 stops after checking that step (no further edge).
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int abort_at,
                           output int ndone, output int nwr);
    step_t q[$];
    step_t e;
    int    stalls;
    ndone = 0; nwr = 0;
    for (int i = 0; i < wf; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom)});
    case (op)
      6'h23: begin
        q.push_back('{2, 1'($urandom)});
        for (int i = 0; i < wm; i++) q.push_back('{3, 1'b0});
        q.push_back('{3, 1'b1});
        q.push_back('{4, 1'($urandom)});
      end
      6'h2B: begin
        q.push_back('{2, 1'($urandom)});
        for (int i = 0; i < wm; i++) q.push_back('{5, 1'b0});
        q.push_back('{5, 1'b1});
      end
      6'h00: begin q.push_back('{6, 1'($urandom)}); q.push_back('{7, 1'($urandom)}); end
      6'h04: q.push_back('{8, 1'($urandom)});
      6'h02: q.push_back('{9, 1'($urandom)});
      6'h08: begin q.push_back('{10, 1'($urandom)}); q.push_back('{11, 1'($urandom)}); end
      default: q.push_back('{12, 1'($urandom)});
    endcase
    opcode = op;
    stalls = 0;
    foreach (q[i]) begin
      e = q[i];
      mem_ready = e.r;
      @(negedge clock);
      chk($sformatf("state op=%0h step%0d", op, i), 32'(state), 32'(e.s));
      chk($sformatf("ctrl op=%0h st=%0d", op, e.s), 32'(dut_w), 32'(exp_w(e.s, e.r)));
      chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
      if (mem_write) nwr++;
      if (instr_done && ndone == 0) ndone = i + 1;
      if (i == abort_at) return;
      @(posedge clock); #1;
    end
  endtask

  int ndone, nwr;
  logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

  initial begin
    // reset state
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_done", 32'(instr_done), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // lw, no stalls: 0,1,2,3,4 with done only in last step
    run_instr(6'h23, 0, 0, -1, ndone, nwr);
    chk("lw_latency", 32'(ndone), 32'd5);

    // sw with two MEM_WR stalls
    run_instr(6'h2B, 0, 2, -1, ndone, nwr);
    chk("sw_latency", 32'(ndone), 32'd6);
    chk("sw_wr_cycles", 32'(nwr), 32'd3);

    // R then beq, addi then j back-to-back
    run_instr(6'h00, 0, 0, -1, ndone, nwr);
    chk("r_latency", 32'(ndone), 32'd4);
    run_instr(6'h04, 0, 0, -1, ndone, nwr);
    chk("beq_latency", 32'(ndone), 32'd3);
    run_instr(6'h08, 0, 0, -1, ndone, nwr);
    chk("addi_latency", 32'(ndone), 32'd4);
    run_instr(6'h02, 0, 0, -1, ndone, nwr);
    chk("j_latency", 32'(ndone), 32'd3);

    // randomized instruction stream with random stalls
    for (int n = 0; n < 60; n++) begin
      int k, wf, wm;
      k  = int'($urandom_range(0, 5));
      wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(ops[k], wf, wm, -1, ndone, nwr);
      case (ops[k])
        6'h23:        chk("rnd_lw_lat", 32'(ndone), 32'(5 + wf + wm));
        6'h2B:        chk("rnd_sw_lat", 32'(ndone), 32'(4 + wf + wm));
        6'h00, 6'h08: chk("rnd_4_lat", 32'(ndone), 32'(4 + wf));
        default:      chk("rnd_3_lat", 32'(ndone), 32'(3 + wf));
      endcase
    end

    // reset while stalled in MEM_RD
    run_instr(6'h23, 0, 1, 3, ndone, nwr);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_ctrl_lo", 32'(dut_w), 32'(exp_w(0, 1'b0)));
    mem_ready = 1'b1;
    #1;
    chk("mrst_ctrl_hi", 32'(dut_w), 32'(exp_w(0, 1'b1)));
    @(posedge clock); #1;
    chk("mrst_hold", 32'(state), 32'd0);
    reset_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clock);
    chk("mrst_rel_state", 32'(state), 32'd0);
    chk("mrst_rel_ctrl", 32'(dut_w), 32'(exp_w(0, 1'b0)));
    @(posedge clock); #1;
    run_instr(6'h00, 0, 0, -1, ndone, nwr);
    chk("post_rst_r_lat", 32'(ndone), 32'd4);

    // illegal opcode: frozen in HALT regardless of inputs
    run_instr(6'h3F, 0, 0, -1, ndone, nwr);
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom);
      mem_ready = 1'($urandom);
      @(negedge clock);
      chk("halt_state", 32'(state), 32'd12);
      chk("halt_ctrl", 32'(dut_w), 32'(exp_w(12, mem_ready)));
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #2;
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_halted", 32'(halted), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    run_instr(6'h08, 1, 0, -1, ndone, nwr);
    chk("halt_recover_lat", 32'(ndone), 32'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout reached t=%0t", $time);
    $fatal(1);
  end

endmodule
